// File: rtl/and2_sweep_checker_if.sv
// Stimulus/result bundle between and2_sweep_checker and its environment.
// master: environment side (drives start and the gate output y).
// slave : checker side (drives gate inputs a/b and the run results).
interface and2_sweep_checker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             y;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] vec_cnt;
    logic [1:0]       fail_vec;
    logic             fail_valid;

    modport master (
        output start, y,
        input  a, b, busy, done, pass, err_cnt, vec_cnt, fail_vec, fail_valid
    );

    modport slave (
        input  start, y,
        output a, b, busy, done, pass, err_cnt, vec_cnt, fail_vec, fail_valid
    );
endinterface

// File: rtl/and2_sweep_checker.sv
// Sweeps {a,b} = 00,01,10,11 for SWEEPS passes into an external AND gate,
// waits SETTLE cycles per vector, compares y with a&b and reports
// saturating mismatch/vector counts, the first failing vector and a verdict.
// Ports: clk, rst (sync, active-high), bus (slave modport: start, y in;
//        a, b, busy, done, pass, err_cnt, vec_cnt, fail_vec, fail_valid out).
module and2_sweep_checker #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned SWEEPS = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    and2_sweep_checker_if.slave  bus
);
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SW_W  = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [SW_W-1:0]  sweep;
    logic [SET_W-1:0] scnt;

    // Single-process FSM; every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= 2'd0;
            sweep          <= '0;
            scnt           <= '0;
            bus.a          <= 1'b0;
            bus.b          <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.err_cnt    <= '0;
            bus.vec_cnt    <= '0;
            bus.fail_vec   <= 2'b00;
            bus.fail_valid <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    bus.a <= 1'b0;
                    bus.b <= 1'b0;
                    if (bus.start) begin
                        state          <= S_DRIVE;
                        bus.busy       <= 1'b1;
                        bus.err_cnt    <= '0;
                        bus.vec_cnt    <= '0;
                        bus.fail_vec   <= 2'b00;
                        bus.fail_valid <= 1'b0;
                        bus.pass       <= 1'b0;
                        idx            <= 2'd0;
                        sweep          <= '0;
                    end
                end
                S_DRIVE: begin
                    {bus.a, bus.b} <= idx;
                    scnt           <= SET_W'(SETTLE - 1);
                    state          <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (scnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        scnt <= scnt - SET_W'(1);
                    end
                end
                S_CHECK: begin
                    if (bus.vec_cnt != '1) begin
                        bus.vec_cnt <= bus.vec_cnt + CNT_W'(1);
                    end
                    if (bus.y != (bus.a & bus.b)) begin
                        if (bus.err_cnt != '1) begin
                            bus.err_cnt <= bus.err_cnt + CNT_W'(1);
                        end
                        // Only the first failure of the run is kept.
                        if (!bus.fail_valid) begin
                            bus.fail_vec   <= {bus.a, bus.b};
                            bus.fail_valid <= 1'b1;
                        end
                    end
                    if (idx == 2'd3 && sweep == SW_W'(SWEEPS - 1)) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        if (idx == 2'd3) begin
                            sweep <= sweep + SW_W'(1);
                        end
                        idx   <= idx + 2'd1;
                        state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    // fail_valid already reflects the last CHECK of the run.
                    bus.pass <= ~bus.fail_valid;
                    bus.a    <= 1'b0;
                    bus.b    <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_and2_sweep_checker.sv
// Self-checking bench for and2_sweep_checker: directed runs against a good
// AND gate, a stuck-at-0 output and an OR gate, with a scoreboard of
// expected run results popped by per-instance monitors on each done pulse.
module tb_and2_sweep_checker;
    typedef struct {
        int err;
        int vec;
        int fv;
        int fvalid;
        int pass;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   gate0 = 0;  // 0: AND, 1: stuck at 0, 2: OR
    exp_t q0[$];
    exp_t q1[$];
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;
    int   pexp0 = 0;
    int   pexp1 = 0;
    int   done_cnt0 = 0;
    int   done_cnt1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    and2_sweep_checker_if #(.CNT_W(8)) bus0();
    and2_sweep_checker_if #(.CNT_W(2)) bus1();

    assign bus0.y = (gate0 == 0) ? (bus0.a & bus0.b) :
                    (gate0 == 1) ? 1'b0 : (bus0.a | bus0.b);
    assign bus1.y = bus1.a | bus1.b;

    and2_sweep_checker #(.SETTLE(2), .SWEEPS(1), .CNT_W(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    and2_sweep_checker #(.SETTLE(2), .SWEEPS(2), .CNT_W(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int err, input int vec, input int fv,
                                input int fvalid, input int pass);
        exp_t e;
        e.err = err; e.vec = vec; e.fv = fv; e.fvalid = fvalid; e.pass = pass;
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic mon0();
        exp_t e;
        forever begin
            @(negedge clk);
            if (pend0) begin
                chk("dut0_pass", int'(bus0.pass), pexp0);
                pend0 = 1'b0;
            end
            if (bus0.done) begin
                done_cnt0++;
                chk("dut0_done_expected", int'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("dut0_latency", cyc, e.done_cyc);
                    chk("dut0_err_cnt", int'(bus0.err_cnt), e.err);
                    chk("dut0_vec_cnt", int'(bus0.vec_cnt), e.vec);
                    chk("dut0_fail_vec", int'(bus0.fail_vec), e.fv);
                    chk("dut0_fail_valid", int'(bus0.fail_valid), e.fvalid);
                    chk("dut0_busy_low", int'(bus0.busy), 0);
                    pexp0 = e.pass;
                    pend0 = 1'b1;
                end
            end
        end
    endtask

    task automatic mon1();
        exp_t e;
        forever begin
            @(negedge clk);
            if (pend1) begin
                chk("dut1_pass", int'(bus1.pass), pexp1);
                pend1 = 1'b0;
            end
            if (bus1.done) begin
                done_cnt1++;
                chk("dut1_done_expected", int'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("dut1_latency", cyc, e.done_cyc);
                    chk("dut1_err_cnt", int'(bus1.err_cnt), e.err);
                    chk("dut1_vec_cnt", int'(bus1.vec_cnt), e.vec);
                    chk("dut1_fail_vec", int'(bus1.fail_vec), e.fv);
                    chk("dut1_fail_valid", int'(bus1.fail_valid), e.fvalid);
                    pexp1 = e.pass;
                    pend1 = 1'b1;
                end
            end
        end
    endtask

    // Launch a dut0 run; returns half a cycle after the accepting edge.
    task automatic run0(input int gate, input exp_t e_in);
        exp_t e;
        e = e_in;
        gate0 = gate;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        e.done_cyc = cyc + 16;
        q0.push_back(e);
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    task automatic wait0(input string name, input int budget);
        for (int i = 0; i < budget && (q0.size() != 0 || pend0); i++) @(negedge clk);
        chk(name, int'(q0.size() == 0 && !pend0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic stim();
        int d;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ab", int'({bus0.a, bus0.b}), 0);
        chk("rst_busy", int'(bus0.busy), 0);
        chk("rst_done", int'(bus0.done), 0);
        chk("rst_pass", int'(bus0.pass), 0);
        chk("rst_counts", int'(bus0.err_cnt) + int'(bus0.vec_cnt), 0);
        chk("rst_fail", int'({bus0.fail_valid, bus0.fail_vec}), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: good gate, also follow the vector sequence and busy.
        run0(0, mk(0, 4, 0, 0, 1));
        for (int i = 0; i < 4; i++) begin
            repeat ((i == 0) ? 2 : 4) @(posedge clk);
            #1;
            chk("s1_vector", int'({bus0.a, bus0.b}), i);
            chk("s1_busy", int'(bus0.busy), 1);
        end
        wait0("s1_complete", 40);
        chk("s1_ab_idle", int'({bus0.a, bus0.b}), 0);

        // 2: y stuck at 0, only 11 fails.
        run0(1, mk(1, 4, 3, 1, 0));
        wait0("s2_complete", 40);

        // 3: OR gate, 01 and 10 fail, first one kept.
        run0(2, mk(2, 4, 1, 1, 0));
        wait0("s3_complete", 40);

        // 4: start re-pulsed mid-run is ignored.
        d = done_cnt0;
        run0(0, mk(0, 4, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(negedge clk);
            bus0.start = 1'b1;
            @(negedge clk);
            bus0.start = 1'b0;
        end
        wait0("s4_complete", 40);
        repeat (20) @(negedge clk);
        chk("s4_single_done", done_cnt0 - d, 1);

        // 5: reset during SETTLE of vector 10 (OR gate so 01 has already failed).
        d = done_cnt0;
        run0(2, mk(0, 0, 0, 0, 0));
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("s5_pre_err", int'(bus0.err_cnt), 1);
        chk("s5_pre_ab", int'({bus0.a, bus0.b}), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        chk("s5_ab", int'({bus0.a, bus0.b}), 0);
        chk("s5_busy", int'(bus0.busy), 0);
        chk("s5_err", int'(bus0.err_cnt), 0);
        chk("s5_vec", int'(bus0.vec_cnt), 0);
        chk("s5_pass", int'(bus0.pass), 0);
        chk("s5_fail_valid", int'(bus0.fail_valid), 0);
        chk("s5_done", int'(bus0.done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("s5_no_done", done_cnt0 - d, 0);
        run0(0, mk(0, 4, 0, 0, 1));
        wait0("s5_rerun_complete", 40);

        // 6: CNT_W=2, SWEEPS=2, OR gate: both counters saturate at 3.
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e = mk(3, 3, 1, 1, 0);
            e.done_cyc = cyc + 32;
            q1.push_back(e);
        end
        @(negedge clk);
        bus1.start = 1'b0;
        for (int i = 0; i < 60 && (q1.size() != 0 || pend1); i++) @(negedge clk);
        chk("s6_complete", int'(q1.size() == 0 && !pend1), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        fork
            mon0();
            mon1();
            stim();
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
